liteic_axil_reg_slave: RTL and testbench
========================================

// Module: liteic_axil_reg_slave
// PURPOSE
// AXI-Lite responder terminating one interconnect slave slot: a NUM_REGS x DATA_WIDTH register bank.
// Accepts AR/R and AW/W/B transactions from the crossbar slave side, decodes the address against BASE_ADDR,
// returns OKAY/SLVERR/DECERR, and exposes the registers (RW) or samples hardware status (RO) for local logic.
// Max one outstanding read and one outstanding write; the read and write paths run independently.
// PARAMETERS
// ADDR_WIDTH  32           address width, matches AXI_ADDR_WIDTH
// DATA_WIDTH  32           data width, matches AXI_DATA_WIDTH; 32 or 64 only
// BASE_ADDR   32'h0000_0000  region base, aligned to the region size
// NUM_REGS    16           register count, power of 2, >= 2
// RO_MASK     '0           bit i = 1: reg i is read-only and reads status_i slice i
// PORTS
// clk_i        in   1                     clock
// rst_i        in   1                     synchronous active-high reset
// ar_addr_i    in   ADDR_WIDTH            read address
// ar_valid_i   in   1                     read address valid
// ar_ready_o   out  1                     read address ready
// r_data_o     out  DATA_WIDTH            read data
// r_resp_o     out  2                     read response
// r_valid_o    out  1                     read data valid
// r_ready_i    in   1                     read data ready
// aw_addr_i    in   ADDR_WIDTH            write address
// aw_valid_i   in   1                     write address valid
// aw_ready_o   out  1                     write address ready
// w_data_i     in   DATA_WIDTH            write data
// w_strb_i     in   DATA_WIDTH/8          byte strobes
// w_valid_i    in   1                     write data valid
// w_ready_o    out  1                     write data ready
// b_resp_o     out  2                     write response
// b_valid_o    out  1                     write response valid
// b_ready_i    in   1                     write response ready
// regs_o       out  NUM_REGS*DATA_WIDTH   RW register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// status_i     in   NUM_REGS*DATA_WIDTH   RO sources; only RO_MASK slices are used
// wr_pulse_o   out  NUM_REGS              1-cycle pulse per register updated by an OKAY write
// BEHAVIOUR
// Reset (rst_i=1 at posedge): all regs 0; all *_valid_o and *_ready_o, r_data_o, r_resp_o, b_resp_o and
//   wr_pulse_o = 0. Transactions in flight are dropped with no response. Ready outputs rise the cycle after reset deasserts.
// Decode: off = addr - BASE_ADDR (ADDR_WIDTH-bit wrap). Word size = DATA_WIDTH/8. idx = off / word size.
//   off >= NUM_REGS*word size -> DECERR (2'b11). Else addr not word-aligned -> SLVERR (2'b10). Else OKAY (2'b00).
// Read FSM R_IDLE / R_RESP:
//   R_IDLE: ar_ready_o=1. On ar handshake, capture response and data at that edge, go to R_RESP.
//   R_RESP: ar_ready_o=0; r_valid_o=1; r_data_o and r_resp_o stable until the r handshake, then R_IDLE.
//   Latency: AR handshake at cycle N -> r_valid_o at N+1. Back-to-back reads give one read every 2 cycles.
//   Data: RW reg -> stored value; RO reg -> status_i slice sampled at the AR edge; any error -> 0.
// Write FSM W_IDLE / W_RESP:
//   AW and W are accepted independently and in either order. aw_ready_o=1 while in W_IDLE and no AW is held;
//   w_ready_o=1 while in W_IDLE and no W is held. Each handshake latches addr or data+strb.
//   Commit edge is the first edge at which both are held, including the same-cycle handshake of both.
//   At the commit edge: OKAY to an RW reg updates the enabled bytes (w_strb_i bit b -> byte b).
//   OKAY to an RO reg -> SLVERR, no update. Address error -> that error, no update. FSM moves to W_RESP.
//   W_RESP: b_valid_o=1; aw_ready_o=0 and w_ready_o=0; b_resp_o stable until the b handshake, then W_IDLE
//   with the held flags cleared.
//   Latency: later of the AW/W handshakes at cycle N -> b_valid_o at N+1.
//   wr_pulse_o[idx]=1 for the single cycle after the commit edge, only for a successful RW update.
//   A write with all strobes 0 is OKAY with no update and still pulses.
// Read/write collision at the same edge (AR handshake and write commit, same reg): the read returns the pre-write
//   value. A read whose AR handshake is later returns the new value.
// Valid outputs never drop before their handshake. Inputs are ignored when their valid is low.
// TESTING
// 1 Reset: hold rst_i 3 cycles mid-read (r_valid_o=1) -> all outputs 0, regs_o=0, ar_ready_o=1 one cycle after release.
// 2 AW at cycle 2, W at cycle 5 (addr BASE+0x8, data 0xA5A5_1234, strb 4'b0101) -> reg2=0x00A5_0034,
//   b_valid_o at cycle 6 with OKAY, wr_pulse_o[2] pulse at cycle 6.
// 3 Read BASE+0x40 with NUM_REGS=16 -> DECERR, data 0. Read BASE+0x6 -> SLVERR.
//   Write to an RO reg -> SLVERR and regs_o unchanged.
// 4 Backpressure: hold r_ready_i=0 for 5 cycles -> r_valid_o, r_data_o and r_resp_o stable and ar_ready_o=0
//   throughout. Hold b_ready_i=0 for 5 cycles -> AW/W not accepted.
// 5 Collision: reg1=0x11; AR and write commit (data 0x22) to reg1 at the same edge -> read returns 0x11, reg1=0x22.
// 6 Random AW/W/AR ordering with valid/ready throttling, 10k transactions -> scoreboard matches a reference register model.

Source files
------------

// File: rtl/liteic_axil_reg_slave.sv
// AXI-Lite register-bank responder for one interconnect slave slot.
// Independent read and write engines, one outstanding transaction each, with RW registers and RO status taps.
module liteic_axil_reg_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [ADDR_WIDTH-1:0]            ar_addr_i,
   input  logic                             ar_valid_i,
   output logic                             ar_ready_o,
   output logic [DATA_WIDTH-1:0]            r_data_o,
   output logic [1:0]                       r_resp_o,
   output logic                             r_valid_o,
   input  logic                             r_ready_i,
   input  logic [ADDR_WIDTH-1:0]            aw_addr_i,
   input  logic                             aw_valid_i,
   output logic                             aw_ready_o,
   input  logic [DATA_WIDTH-1:0]            w_data_i,
   input  logic [DATA_WIDTH/8-1:0]          w_strb_i,
   input  logic                             w_valid_i,
   output logic                             w_ready_o,
   output logic [1:0]                       b_resp_o,
   output logic                             b_valid_o,
   input  logic                             b_ready_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   status_i,
   output logic [NUM_REGS-1:0]              wr_pulse_o
);

   localparam int                    STRB_WIDTH   = DATA_WIDTH / 8;
   localparam int                    OFF_LSB      = $clog2(STRB_WIDTH);
   localparam int                    IDX_WIDTH    = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(NUM_REGS * STRB_WIDTH);
   localparam logic [1:0]            RESP_OKAY    = 2'b00;
   localparam logic [1:0]            RESP_SLVERR  = 2'b10;
   localparam logic [1:0]            RESP_DECERR  = 2'b11;

   typedef enum logic {R_IDLE, R_RESP} r_state_t;
   typedef enum logic {W_IDLE, W_RESP} w_state_t;

   // Out-of-region beats DECERR before alignment is considered.
   function automatic logic [1:0] off_resp(input logic [ADDR_WIDTH-1:0] off);
      if (off >= REGION_BYTES)
         return RESP_DECERR;
      if (off[OFF_LSB-1:0] != '0)
         return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   logic [DATA_WIDTH-1:0] reg_bank_reg [NUM_REGS];
   logic [DATA_WIDTH-1:0] status_arr   [NUM_REGS];
   logic                  ready_en_reg;

   // ---------------- read path ----------------
   r_state_t              r_state_reg, r_state_next;
   logic [ADDR_WIDTH-1:0] ar_off;
   logic [IDX_WIDTH-1:0]  ar_idx;
   logic [1:0]            ar_resp;
   logic [DATA_WIDTH-1:0] ar_data;
   logic                  ar_hs;
   logic [DATA_WIDTH-1:0] r_data_reg;
   logic [1:0]            r_resp_reg;

   assign ar_off  = ar_addr_i - BASE_ADDR;
   assign ar_idx  = ar_off[OFF_LSB +: IDX_WIDTH];
   assign ar_resp = off_resp(ar_off);
   assign ar_hs   = ar_valid_i && ar_ready_o;

   always_comb begin
      ar_data = '0;
      if (ar_resp == RESP_OKAY)
         ar_data = RO_MASK[ar_idx] ? status_arr[ar_idx] : reg_bank_reg[ar_idx];
   end

   always_comb begin
      r_state_next = r_state_reg;
      ar_ready_o   = 1'b0;
      r_valid_o    = 1'b0;
      case (r_state_reg)
         R_IDLE: begin
            ar_ready_o = ready_en_reg;
            if (ar_valid_i && ready_en_reg)
               r_state_next = R_RESP;
         end
         R_RESP: begin
            r_valid_o = 1'b1;
            if (r_ready_i)
               r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // The bank is sampled before any same-edge write lands, so a colliding read sees the old value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_reg <= R_IDLE;
         r_data_reg  <= '0;
         r_resp_reg  <= RESP_OKAY;
      end else begin
         r_state_reg <= r_state_next;
         if (ar_hs) begin
            r_data_reg <= ar_data;
            r_resp_reg <= ar_resp;
         end
      end
   end

   assign r_data_o = r_data_reg;
   assign r_resp_o = r_resp_reg;

   // ---------------- write path ----------------
   w_state_t              w_state_reg, w_state_next;
   logic                  aw_held_reg, w_held_reg;
   logic [ADDR_WIDTH-1:0] aw_addr_reg;
   logic [DATA_WIDTH-1:0] w_data_reg;
   logic [STRB_WIDTH-1:0] w_strb_reg;
   logic                  aw_hs, w_hs, commit;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_off;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic [1:0]            wr_addr_resp, wr_resp;
   logic                  wr_ok;
   logic [1:0]            b_resp_reg;
   logic [NUM_REGS-1:0]   wr_pulse_reg;

   assign aw_hs = aw_valid_i && aw_ready_o;
   assign w_hs  = w_valid_i && w_ready_o;

   always_comb begin
      w_state_next = w_state_reg;
      aw_ready_o   = 1'b0;
      w_ready_o    = 1'b0;
      b_valid_o    = 1'b0;
      commit       = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            aw_ready_o = ready_en_reg && !aw_held_reg;
            w_ready_o  = ready_en_reg && !w_held_reg;
            if ((aw_held_reg || (aw_valid_i && aw_ready_o)) &&
                (w_held_reg  || (w_valid_i  && w_ready_o))) begin
               commit       = 1'b1;
               w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i)
               w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // A commit may use a held beat, a live beat, or one of each.
   assign wr_addr      = aw_held_reg ? aw_addr_reg : aw_addr_i;
   assign wr_data      = w_held_reg  ? w_data_reg  : w_data_i;
   assign wr_strb      = w_held_reg  ? w_strb_reg  : w_strb_i;
   assign wr_off       = wr_addr - BASE_ADDR;
   assign wr_idx       = wr_off[OFF_LSB +: IDX_WIDTH];
   assign wr_addr_resp = off_resp(wr_off);
   assign wr_resp      = (wr_addr_resp == RESP_OKAY && RO_MASK[wr_idx]) ? RESP_SLVERR : wr_addr_resp;
   assign wr_ok        = commit && (wr_resp == RESP_OKAY);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_reg  <= W_IDLE;
         aw_held_reg  <= 1'b0;
         w_held_reg   <= 1'b0;
         b_resp_reg   <= RESP_OKAY;
         wr_pulse_reg <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         w_state_reg  <= w_state_next;
         wr_pulse_reg <= '0;
         ready_en_reg <= 1'b1;
         if (commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            b_resp_reg  <= wr_resp;
            if (wr_ok)
               wr_pulse_reg[wr_idx] <= 1'b1;
         end else begin
            if (aw_hs)
               aw_held_reg <= 1'b1;
            if (w_hs)
               w_held_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (aw_hs)
         aw_addr_reg <= aw_addr_i;
      if (w_hs) begin
         w_data_reg <= w_data_i;
         w_strb_reg <= w_strb_i;
      end
   end

   assign b_resp_o   = b_resp_reg;
   assign wr_pulse_o = wr_pulse_reg;

   // ---------------- register bank ----------------
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign status_arr[gi]                        = status_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH]   = reg_bank_reg[gi];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            reg_bank_reg[gi] <= '0;
         end else if (wr_ok && wr_idx == IDX_WIDTH'(gi)) begin
            for (int b = 0; b < STRB_WIDTH; b++)
               if (wr_strb[b])
                  reg_bank_reg[gi][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_liteic_axil_reg_slave.sv
// Directed plus randomized checks of liteic_axil_reg_slave against a word-level register model.
// Every task starts and ends 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_liteic_axil_reg_slave;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [15:0] RO   = 16'h8030;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   ar_addr;
   logic          ar_valid;
   logic          ar_ready;
   logic [31:0]   r_data;
   logic [1:0]    r_resp;
   logic          r_valid;
   logic          r_ready;
   logic [31:0]   aw_addr;
   logic          aw_valid;
   logic          aw_ready;
   logic [31:0]   w_data;
   logic [3:0]    w_strb;
   logic          w_valid;
   logic          w_ready;
   logic [1:0]    b_resp;
   logic          b_valid;
   logic          b_ready;
   logic [511:0]  regs;
   logic [511:0]  status;
   logic [15:0]   wr_pulse;

   int            n_cmp = 0;
   int            n_mis = 0;
   logic [31:0]   mdl [16];

   always #5 clk = ~clk;

   liteic_axil_reg_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .BASE_ADDR  (BASE),
      .NUM_REGS   (16),
      .RO_MASK    (RO)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ar_addr_i  (ar_addr),
      .ar_valid_i (ar_valid),
      .ar_ready_o (ar_ready),
      .r_data_o   (r_data),
      .r_resp_o   (r_resp),
      .r_valid_o  (r_valid),
      .r_ready_i  (r_ready),
      .aw_addr_i  (aw_addr),
      .aw_valid_i (aw_valid),
      .aw_ready_o (aw_ready),
      .w_data_i   (w_data),
      .w_strb_i   (w_strb),
      .w_valid_i  (w_valid),
      .w_ready_o  (w_ready),
      .b_resp_o   (b_resp),
      .b_valid_o  (b_valid),
      .b_ready_i  (b_ready),
      .regs_o     (regs),
      .status_i   (status),
      .wr_pulse_o (wr_pulse)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mdl_vec();
      logic [511:0] v;
      for (int i = 0; i < 16; i++)
         v[i*32 +: 32] = mdl[i];
      return v;
   endfunction

   // Reference decode: region check, then alignment, then (for writes) read-only protection.
   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_write);
      logic [31:0] off;
      off = addr - BASE;
      if (off >= 32'd64)  return 2'b11;
      if (off % 4 != 0)   return 2'b10;
      if (is_write && RO[off / 4]) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
      logic [31:0] off;
      int idx;
      off = addr - BASE;
      if (exp_resp(addr, 1'b0) != 2'b00) return 32'h0;
      idx = int'(off / 4);
      return RO[idx] ? status[idx*32 +: 32] : mdl[idx];
   endfunction

   function automatic void mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      idx = int'((addr - BASE) / 4);
      for (int b = 0; b < 4; b++)
         if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return $urandom;
         1:       return BASE + $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
         2:       return BASE + 64 + $urandom_range(0, 255);
         default: return BASE + $urandom_range(0, 15) * 4;
      endcase
   endfunction

   task automatic randomize_status();
      for (int i = 0; i < 16; i++)
         status[i*32 +: 32] = $urandom;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output logic [15:0] pulse);
      bit aw_done = 0;
      bit w_done  = 0;
      bit aw_hs, w_hs;
      int k = 0;
      while (!(aw_done && w_done)) begin
         aw_valid = !aw_done && k >= aw_dly;
         aw_addr  = aw_valid ? addr : $urandom;
         w_valid  = !w_done && k >= w_dly;
         w_data   = w_valid ? data : $urandom;
         w_strb   = w_valid ? strb : 4'($urandom);
         @(negedge clk);
         aw_hs = aw_valid && aw_ready;
         w_hs  = w_valid && w_ready;
         @(posedge clk); #1;
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         k++;
         if (k > 40) begin
            check("aw_w_accept_timeout", 1'b0, 1'b1);
            break;
         end
      end
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      @(negedge clk);
      check("b_valid_latency", b_valid, 1'b1);
      resp  = b_resp;
      pulse = wr_pulse;
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         check("b_hold_valid", b_valid, 1'b1);
         check("b_hold_resp", b_resp, resp);
         check("b_hold_no_accept", {aw_ready, w_ready}, 2'b00);
         check("b_hold_pulse_gone", wr_pulse, 16'h0);
      end
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
      bit hs = 0;
      int k = 0;
      while (!hs) begin
         ar_valid = k >= ar_dly;
         ar_addr  = ar_valid ? addr : $urandom;
         @(negedge clk);
         hs = ar_valid && ar_ready;
         @(posedge clk); #1;
         k++;
         if (k > 40) begin
            check("ar_accept_timeout", 1'b0, 1'b1);
            break;
         end
      end
      ar_valid = 1'b0;
      @(negedge clk);
      check("r_valid_latency", r_valid, 1'b1);
      data = r_data;
      resp = r_resp;
      for (int i = 0; i < r_dly; i++) begin
         randomize_status();
         @(negedge clk);
         check("r_hold_valid", r_valid, 1'b1);
         check("r_hold_data", r_data, data);
         check("r_hold_resp", r_resp, resp);
         check("r_hold_ar_ready", ar_ready, 1'b0);
      end
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      logic [15:0] pulse;
      logic [31:0] addr;
      logic [3:0]  strb;

      rst = 1'b1;
      ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
      aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
      status = '0;
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a read that is waiting on r_ready.
      axi_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, pulse);
      check("pre_reset_write_resp", resp, 2'b00);
      ar_addr = BASE; ar_valid = 1'b1;
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(negedge clk);
      check("pre_reset_r_valid", r_valid, 1'b1);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valids", {r_valid, b_valid}, 2'b00);
      check("reset_readys", {ar_ready, aw_ready, w_ready}, 3'b000);
      check("reset_r_data", r_data, 32'h0);
      check("reset_resps", {r_resp, b_resp}, 4'h0);
      check("reset_wr_pulse", wr_pulse, 16'h0);
      check("reset_regs", regs, 512'h0);
      rst = 1'b0;
      check("release_ar_ready_not_yet", ar_ready, 1'b0);
      @(negedge clk);
      check("release_readys", {ar_ready, aw_ready, w_ready}, 3'b111);
      @(posedge clk); #1;

      // AW two cycles in, W five cycles in, partial strobes.
      axi_write(BASE + 32'h8, 32'hA5A5_1234, 4'b0101, 2, 5, 2, resp, pulse);
      mdl_write(BASE + 32'h8, 32'hA5A5_1234, 4'b0101);
      check("split_write_resp", resp, 2'b00);
      check("split_write_pulse", pulse, 16'h0004);
      check("split_write_reg2", regs[2*32 +: 32], 32'h00A5_0034);

      // Error decode and read-only protection.
      axi_read(BASE + 32'h40, 0, 0, data, resp);
      check("decerr_resp", resp, 2'b11);
      check("decerr_data", data, 32'h0);
      axi_read(BASE + 32'h6, 1, 0, data, resp);
      check("slverr_resp", resp, 2'b10);
      check("slverr_data", data, 32'h0);
      axi_write(BASE + 32'h10, 32'h1234_5678, 4'hF, 0, 0, 0, resp, pulse);
      check("ro_write_resp", resp, 2'b10);
      check("ro_write_pulse", pulse, 16'h0);
      check("ro_write_regs", regs, mdl_vec());
      axi_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, resp, pulse);
      check("zero_strb_resp", resp, 2'b00);
      check("zero_strb_pulse", pulse, 16'h0008);
      check("zero_strb_regs", regs, mdl_vec());
      status[4*32 +: 32] = 32'hCAFE_F00D;
      axi_read(BASE + 32'h10, 0, 0, data, resp);
      check("ro_read_data", data, 32'hCAFE_F00D);

      // Backpressure on both response channels.
      axi_read(BASE + 32'h8, 0, 5, data, resp);
      check("bp_read_data", data, 32'h00A5_0034);
      axi_write(BASE + 32'h20, 32'h0BAD_CAFE, 4'hF, 0, 0, 5, resp, pulse);
      mdl_write(BASE + 32'h20, 32'h0BAD_CAFE, 4'hF);
      check("bp_write_resp", resp, 2'b00);

      // Read and write commit to the same register on the same edge.
      axi_write(BASE + 32'h4, 32'h11, 4'hF, 0, 0, 0, resp, pulse);
      mdl_write(BASE + 32'h4, 32'h11, 4'hF);
      ar_addr = BASE + 32'h4; ar_valid = 1'b1;
      aw_addr = BASE + 32'h4; aw_valid = 1'b1;
      w_data  = 32'h22; w_strb = 4'hF; w_valid = 1'b1;
      @(negedge clk);
      check("collide_same_edge", {ar_ready, aw_ready, w_ready}, 3'b111);
      @(posedge clk); #1;
      ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      check("collide_r_data_old", {r_valid, r_data}, {1'b1, 32'h11});
      check("collide_b", {b_valid, b_resp}, 3'b100);
      check("collide_reg1_new", regs[1*32 +: 32], 32'h22);
      r_ready = 1'b1; b_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0; b_ready = 1'b0;
      mdl_write(BASE + 32'h4, 32'h22, 4'hF);
      axi_read(BASE + 32'h4, 0, 0, data, resp);
      check("after_collide_read", data, 32'h22);

      // Randomized mix against the reference model.
      for (int t = 0; t < 10000; t++) begin
         addr = rand_addr();
         if ($urandom_range(0, 1) == 1) begin
            logic [1:0]  er;
            logic [15:0] ep;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            er   = exp_resp(addr, 1'b1);
            ep   = (er == 2'b00) ? (16'h1 << ((addr - BASE) / 4)) : 16'h0;
            if (er == 2'b00) mdl_write(addr, data, strb);
            axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 1), resp, pulse);
            check("rand_write_resp", resp, er);
            check("rand_write_pulse", pulse, ep);
            check("rand_write_regs", regs, mdl_vec());
         end else begin
            logic [31:0] ed;
            logic [1:0]  er;
            randomize_status();
            ed = exp_rdata(addr);
            er = exp_resp(addr, 1'b0);
            axi_read(addr, $urandom_range(0, 1), $urandom_range(0, 1), data, resp);
            check("rand_read_data", data, ed);
            check("rand_read_resp", resp, er);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
